impulse_reader: RTL

//  Read-side sequencer for impulse_memory. On each audio-sample start strobe it

---
 rtl/impulse_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/impulse_reader.sv
// impulse_reader: read-side sequencer for impulse_memory.
// Sweeps read_addr over 0..N-1 after each start_in pulse and delays
// {valid, index, last} by READ_LATENCY so they line up with read_data.
// Ports:
//   clk_in, rst_in (async active-low)      clock / reset
//   start_in, impulse_length               sweep request and tap count
//   read_addr -> / read_data <-            impulse_memory port B
//   tap_out, tap_index_out, tap_valid_out,
//   tap_last_out                           tap stream to the MAC
//   busy_out, done_out, overrun_out        status
module impulse_reader #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] impulse_length,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] tap_out,
  output logic [ADDR_WIDTH-1:0] tap_index_out,
  output logic                  tap_valid_out,
  output logic                  tap_last_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  overrun_out
);

  localparam int unsigned LAST_STG = READ_LATENCY - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;
  logic                  r_overrun;

  // Delay pipe aligning issued-address metadata with the BRAM read latency
  logic                  r_pv    [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pidx  [READ_LATENCY];
  logic                  r_plast [READ_LATENCY];

  logic                  w_accept;
  logic                  w_addr_is_last;
  logic                  w_pipe_last;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_len_nxt;
  logic                  w_done_nxt;
  logic                  w_overrun_nxt;

  assign w_accept       = start_in && (r_state == S_IDLE);
  assign w_addr_is_last = (r_addr == (r_len - ADDR_WIDTH'(1)));
  assign w_pipe_last    = r_pv[LAST_STG] && r_plast[LAST_STG];

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (impulse_length != '0)) w_next_state = S_SWEEP;
      S_SWEEP: if (w_addr_is_last) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pipe_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_issue       = 1'b0;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = r_overrun || (start_in && (r_state != S_IDLE));
    case (r_state)
      S_IDLE: begin
        w_addr_nxt = '0;
        if (w_accept) begin
          w_len_nxt  = impulse_length;
          // Zero-length request completes immediately without sweeping
          w_done_nxt = (impulse_length == '0);
        end
      end
      S_SWEEP: begin
        w_issue    = 1'b1;
        w_addr_nxt = w_addr_is_last ? '0 : (r_addr + ADDR_WIDTH'(1));
      end
      S_DRAIN: begin
        w_addr_nxt = '0;
        w_done_nxt = w_pipe_last;
      end
      default: w_addr_nxt = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_len     <= '0;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        r_pv[i]    <= 1'b0;
        r_pidx[i]  <= '0;
        r_plast[i] <= 1'b0;
      end
    end else begin
      r_len      <= w_len_nxt;
      r_addr     <= w_addr_nxt;
      r_done     <= w_done_nxt;
      r_overrun  <= w_overrun_nxt;
      r_pv[0]    <= w_issue;
      r_pidx[0]  <= r_addr;
      r_plast[0] <= w_issue && w_addr_is_last;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pidx[i]  <= r_pidx[i-1];
        r_plast[i] <= r_plast[i-1];
      end
    end
  end

  assign read_addr     = r_addr;
  assign tap_valid_out = r_pv[LAST_STG];
  assign tap_index_out = r_pidx[LAST_STG];
  assign tap_last_out  = w_pipe_last;
  // read_data passes straight through; gated so it reads 0 when no tap is valid
  assign tap_out       = r_pv[LAST_STG] ? read_data : '0;
  assign busy_out      = (r_state != S_IDLE);
  assign done_out      = r_done;
  assign overrun_out   = r_overrun;

endmodule
